// File: rtl/writeback_pipe_pkg.sv
// Shared encodings and defaults for the writeback pipe and its load-extension unit.
package writeback_pipe_pkg;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_e;

  // Sliced down to REG_AW bits by the top, giving the all-ones link register.
  localparam logic [31:0] DEFAULT_LINK_REG = '1;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/writeback_pipe_if.sv
// Bus bundle between the execute stage, the writeback pipe and the register-file write port.
interface writeback_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 32
);
  localparam int SEL_W = $clog2(NUM_SRC);

  // Both sides use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; valid, once raised, holds its payload stable until accepted.
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_regwrite;
  logic                      in_link;
  logic [REG_AW-1:0]         in_wreg;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_SRC*DATA_W-1:0] in_src;
  logic [1:0]                in_ld_size;
  logic                      in_ld_signed;
  logic [1:0]                in_ld_off;
  logic                      out_ready;
  logic                      out_valid;
  logic                      rf_we;
  logic [REG_AW-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [CNT_W-1:0]          retired;

  modport master (
    output flush, in_valid, in_regwrite, in_link, in_wreg, in_sel, in_src,
           in_ld_size, in_ld_signed, in_ld_off, out_ready,
    input  in_ready, out_valid, rf_we, rf_waddr, rf_wdata, retired
  );

  modport slave (
    input  flush, in_valid, in_regwrite, in_link, in_wreg, in_sel, in_src,
           in_ld_size, in_ld_signed, in_ld_off, out_ready,
    output in_ready, out_valid, rf_we, rf_waddr, rf_wdata, retired
  );

endinterface

// File: rtl/writeback_pipe_load_extend.sv
// load_extend: aligns a byte/half out of a loaded word by offset, then sign- or zero-extends.
module load_extend
  import writeback_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword offset only looks at off_i[1]; odd halfword offsets are not meaningful.
  assign byte_v = 8'(data_i >> {off_i, 3'b000});
  assign half_v = 16'(data_i >> {off_i[1], 4'b0000});

  always_comb begin
    data_o = data_i;
    if (size_i == LD_BYTE) begin
      data_o = {{(DATA_W-8){signed_i & byte_v[7]}}, byte_v};
    end else if (size_i == LD_HALF) begin
      data_o = {{(DATA_W-16){signed_i & half_v[15]}}, half_v};
    end
  end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: 2-entry FIFO of register writes with retire counter and flush.
// Define WRITEBACK_PIPE_LOAD_EXT_EN to align/extend load data on source 0.
module writeback_pipe
  import writeback_pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter int                NUM_SRC  = 3,
  parameter logic [REG_AW-1:0] LINK_REG = DEFAULT_LINK_REG[REG_AW-1:0],
  parameter int                CNT_W    = 32
) (
  input logic             clk,
  input logic             rst,
  writeback_pipe_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_SRC);

  logic              ready_en_q;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  retired_q;
  logic              regwrite_q [FIFO_DEPTH];
  logic [REG_AW-1:0] waddr_q    [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata_q    [FIFO_DEPTH];

  logic              push, pop;
  logic [DATA_W-1:0] ld_data, sel_data;
  logic [REG_AW-1:0] push_waddr;

`ifdef WRITEBACK_PIPE_LOAD_EXT_EN
  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .data_i   (bus.in_src[DATA_W-1:0]),
    .size_i   (bus.in_ld_size),
    .signed_i (bus.in_ld_signed),
    .off_i    (bus.in_ld_off),
    .data_o   (ld_data)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{bus.in_ld_size, bus.in_ld_signed, bus.in_ld_off};
  assign ld_data   = bus.in_src[DATA_W-1:0];
`endif

  // Out-of-range selects fall through with zero data.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_data = (k == 0) ? ld_data : bus.in_src[k*DATA_W +: DATA_W];
      end
    end
  end

  assign push_waddr = bus.in_link ? LINK_REG : bus.in_wreg;

  // ready_en_q keeps in_ready low through reset and for the edge it is released on.
  assign bus.in_ready  = ready_en_q && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      // A pop in a flush cycle still retired the head, so it is counted.
      if (pop) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      regwrite_q[wr_ptr_q] <= bus.in_regwrite;
      waddr_q[wr_ptr_q]    <= push_waddr;
      wdata_q[wr_ptr_q]    <= sel_data;
    end
  end

  assign bus.rf_waddr = waddr_q[rd_ptr_q];
  assign bus.rf_wdata = wdata_q[rd_ptr_q];
  assign bus.rf_we    = pop && regwrite_q[rd_ptr_q] && (waddr_q[rd_ptr_q] != '0);
  assign bus.retired  = retired_q;

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of result data and register write data.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Parameter NUM_SRC, default 3, number of result sources, minimum 2; SEL_W = clog2(NUM_SRC).
REQ-004 Parameter LINK_REG, default all-ones of REG_AW, destination forced when link is requested.
REQ-005 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  synchronous discard of all buffered entries.
REQ-009 in_valid  in  1  upstream presents an instruction.
REQ-010 in_ready  out  1  stage accepts; a push occurs when in_valid & in_ready.
REQ-011 in_regwrite  in  1  instruction writes the register file.
REQ-012 in_link  in  1  destination overridden to LINK_REG.
REQ-013 in_wreg  in  REG_AW  destination register.
REQ-014 in_sel  in  SEL_W  binary index of the result source.
REQ-015 in_src  in  NUM_SRC*DATA_W  source bus; source k occupies bits [k*DATA_W +: DATA_W]; source 0 is load data.
REQ-016 in_ld_size  in  2  00 byte, 01 half, 1x word; in_ld_signed  in  1; in_ld_off  in  2  byte offset.
REQ-017 out_ready  in  1  register-file port accepts the head entry.
REQ-018 out_valid  out  1  head entry present.
REQ-019 rf_we  out  1; rf_waddr  out  REG_AW; rf_wdata  out  DATA_W  register-file write port.
REQ-020 retired  out  CNT_W  count of entries popped.

Function
REQ-021 Storage SHALL be a 2-entry FIFO of {regwrite, waddr, wdata}; in_ready SHALL be 1 exactly when fewer than 2 entries are held.
REQ-022 At push, wdata SHALL be the in_sel source (after load extension when in_sel==0); in_sel >= NUM_SRC SHALL yield zero.
REQ-023 At push, waddr SHALL be LINK_REG when in_link=1, else in_wreg.
REQ-024 Latency: an entry pushed in cycle N SHALL be visible on the outputs from cycle N+1; no combinational path from in_* to out_valid or rf_*.
REQ-025 A pop occurs when out_valid & out_ready; push and pop in the same cycle SHALL leave the count unchanged.
REQ-026 rf_we SHALL equal out_valid & out_ready & head.regwrite & (head.waddr != 0).
REQ-027 rf_waddr and rf_wdata SHALL show the head entry whenever out_valid=1.
REQ-028 retired SHALL increment by 1 on each pop, including pops with regwrite=0, and SHALL wrap modulo 2^CNT_W.
REQ-029 flush SHALL empty the FIFO at the clock edge; a push or pop in the same cycle SHALL be discarded; retired SHALL still count a same-cycle pop.
REQ-030 Order SHALL be preserved FIFO order; no entry is dropped or duplicated except by flush.

Reset
REQ-031 While rst=1: FIFO empty, out_valid=0, in_ready=0, rf_we=0, retired=0.
REQ-032 After rst falls, in_ready SHALL be 1 from the first clock edge; payload registers need not be reset.

Configuration
REQ-033 Macro WRITEBACK_PIPE_LOAD_EXT_EN defined: source 0 is shifted right by 8*in_ld_off (byte) or 16*in_ld_off[1] (half), then sign- or zero-extended per in_ld_signed and in_ld_size.
REQ-034 Macro undefined: source 0 passes unmodified and in_ld_size, in_ld_signed, in_ld_off are ignored; the port list is unchanged.

Structure
REQ-035 A shared package SHALL hold the load-size encodings (LD_BYTE, LD_HALF, LD_WORD) and the default LINK_REG constant.
REQ-036 Load extension SHALL be a separate sub-module, load_extend, parametrised by DATA_W, and instantiated only under the macro.

Verification
REQ-037 Reset: rst pulse, then check out_valid=0, in_ready=1, retired=0.
REQ-038 Backpressure: out_ready=0, push wreg=3/sel=1/src1=0xA5A5A5A5 then wreg=4 -> in_ready=0 after 2 pushes; raise out_ready -> rf writes reg 3 then reg 4 with correct data; retired=2.
REQ-039 Link and zero: push in_link=1, wreg=7 -> rf_waddr=31; push wreg=0, regwrite=1 -> rf_we=0 and retired still increments.
REQ-040 Flush: two entries held, flush with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, no rf_we.
REQ-041 Load extension (macro on): src0=0x00008000, half, off=0, signed -> 0xFFFF8000; byte, off=1, unsigned -> 0x00000080. Macro off: data 0x00008000 unchanged.
REQ-042 Counter wrap: CNT_W=4, 17 pops -> retired=1.
